// File: rtl/bht_ctrl.sv
// Branch history table: 2^IDX_W two-bit saturating counters, swept to weak-not-taken after reset.
// Optional macro BHT_BYPASS_EN forwards a same-cycle accepted update to a matching lookup.
module bht_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        lookup_en,
  output logic        predict_taken,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred,
  output logic        mispredict,
  output logic        ready,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt,
  output logic        fsm_state
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   init_ptr, init_ptr_nxt;
  logic [1:0]         table_q [DEPTH];
  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic               accept;
  logic [1:0]         upd_old, upd_new, lk_cnt;
  logic               unused_pc_bits;

  assign lk_idx = pcF[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pcF[31:IDX_W+2], pcF[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    case (state)
      S_INIT: begin
        init_ptr_nxt = init_ptr + 1'b1;
        if (&init_ptr) state_nxt = S_RUN;
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  assign ready      = (state == S_RUN);
  assign fsm_state  = state;
  assign accept     = upd_en & ready;
  assign mispredict = accept & (upd_pred ^ upd_taken);

  always_comb begin
    upd_old = table_q[up_idx];
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != 2'd3) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'd0) upd_new = upd_old - 2'd1;
    end
  end

  always_comb begin
    lk_cnt = table_q[lk_idx];
`ifdef BHT_BYPASS_EN
    if (accept && (up_idx == lk_idx)) lk_cnt = upd_new;
`endif
  end

  assign predict_taken = lookup_en & ready & lk_cnt[1];

  // Table has no reset of its own; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT)
        table_q[init_ptr] <= 2'b01;
      else if (accept)
        table_q[up_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (accept) begin
      if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
      if (mispredict && (mispred_cnt != 16'hFFFF)) mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl (IDX_W=4): init sweep, training, aliasing, saturation, bypass, counters, reset.
module tb_bht_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        lookup_en;
  logic        predict_taken;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic        ready;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;
  logic        fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  bht_ctrl #(.IDX_W(4)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .lookup_en(lookup_en),
    .predict_taken(predict_taken), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_pred(upd_pred), .mispredict(mispredict),
    .ready(ready), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let inputs change well clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    upd_en = 1'b1; upd_pc = pc; upd_taken = taken; upd_pred = pred;
    step();
    upd_en = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    lookup_en = 1'b1; pcF = pc;
    #2;
    check(tag, {31'd0, predict_taken}, {31'd0, exp});
    lookup_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pcF = '0; lookup_en = 1'b0;
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0;
    step();
    rst = 1'b0;
    #2;
    check("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check("rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    check("rst_state", {31'd0, fsm_state}, 32'd0);

    // INIT sweep with a mispredicting update and a lookup held on every cycle.
    for (int i = 0; i < 16; i++) begin
      upd_en = 1'b1; upd_pc = 32'h08; upd_taken = 1'b1; upd_pred = 1'b0;
      lookup_en = 1'b1; pcF = 32'h40;
      #2;
      check($sformatf("init_ready_%0d", i), {31'd0, ready}, 32'd0);
      check($sformatf("init_pred_%0d", i), {31'd0, predict_taken}, 32'd0);
      check($sformatf("init_mispred_%0d", i), {31'd0, mispredict}, 32'd0);
      step();
    end
    upd_en = 1'b0; lookup_en = 1'b0;
    #2;
    check("ready_after_16", {31'd0, ready}, 32'd1);
    check("init_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check("init_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);

    // Mispredicted then correctly predicted update.
    upd_en = 1'b1; upd_pc = 32'h08; upd_taken = 1'b1; upd_pred = 1'b0;
    #2;
    check("mispred_comb", {31'd0, mispredict}, 32'd1);
    step();
    upd_en = 1'b0;
    #2;
    check("cnt1_branch", {16'd0, branch_cnt}, 32'd1);
    check("cnt1_mispred", {16'd0, mispred_cnt}, 32'd1);
    upd_en = 1'b1; upd_pc = 32'h0C; upd_taken = 1'b1; upd_pred = 1'b1;
    #2;
    check("correct_no_mispred", {31'd0, mispredict}, 32'd0);
    step();
    upd_en = 1'b0;
    #2;
    check("cnt2_branch", {16'd0, branch_cnt}, 32'd2);
    check("cnt2_mispred", {16'd0, mispred_cnt}, 32'd1);

    // Train index 0 to strong-taken; check aliasing and a neighbour.
    lookup("fresh_0x40", 32'h40, 1'b0);
    update(32'h40, 1'b1, 1'b1);
    lookup("one_taken_0x40", 32'h40, 1'b1);
    update(32'h40, 1'b1, 1'b1);
    lookup("trained_0x40", 32'h40, 1'b1);
    lookup("alias_0x80", 32'h80, 1'b1);
    lookup("neighbour_0x44", 32'h44, 1'b0);
    pcF = 32'h40; lookup_en = 1'b0;
    #2;
    check("lookup_disabled", {31'd0, predict_taken}, 32'd0);

    // Saturation at 3: one not-taken still predicts taken, a second does not.
    for (int i = 0; i < 5; i++) update(32'h40, 1'b1, 1'b1);
    update(32'h40, 1'b0, 1'b1);
    lookup("sat_nt1", 32'h40, 1'b1);
    update(32'h40, 1'b0, 1'b1);
    lookup("sat_nt2", 32'h40, 1'b0);
    check("cnt3_branch", {16'd0, branch_cnt}, 32'd11);
    check("cnt3_mispred", {16'd0, mispred_cnt}, 32'd3);

    // Same-cycle lookup and update on a fresh entry.
    upd_en = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_pred = 1'b0;
    lookup_en = 1'b1; pcF = 32'h10;
    #2;
`ifdef BHT_BYPASS_EN
    check("same_cycle_bypass", {31'd0, predict_taken}, 32'd1);
`else
    check("same_cycle_nobypass", {31'd0, predict_taken}, 32'd0);
`endif
    step();
    upd_en = 1'b0;
    #2;
    check("next_cycle_0x10", {31'd0, predict_taken}, 32'd1);
    check("cnt4_branch", {16'd0, branch_cnt}, 32'd12);
    lookup_en = 1'b0;

    // Reset in RUN clears counters and re-runs the sweep.
    rst = 1'b1;
    lookup_en = 1'b1; pcF = 32'h40;
    step();
    rst = 1'b0;
    #2;
    check("rerst_branch", {16'd0, branch_cnt}, 32'd0);
    check("rerst_mispred", {16'd0, mispred_cnt}, 32'd0);
    check("rerst_ready", {31'd0, ready}, 32'd0);
    check("rerst_pred", {31'd0, predict_taken}, 32'd0);
    for (int i = 0; i < 15; i++) step();
    #2;
    check("rerst_ready_15", {31'd0, ready}, 32'd0);
    begin
      int waited = 0;
      while (!ready && waited < 20) begin
        step();
        waited++;
        #2;
      end
      check("rerst_ready_wait", waited, 32'd1);
    end
    lookup("reinit_0x40", 32'h40, 1'b0);
    lookup("reinit_0x10", 32'h10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
